snn_tick_scheduler: RTL

Timestep sequencer for the two-core SNN. It is a Wishbone slave that sequences each timestep:
- gates host writes into the axon spike memory through `core_en_o`;
- issues per-core start pulses and waits for every enabled core to report done;
- emits a global tick, counts timesteps, and raises completion and timeout interrupts.

It sits beside the spike input memory on the same Wishbone bus and drives that memory's `core_en_i`.

---
 rtl/snn_tick_scheduler.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/snn_tick_scheduler.sv
// Timestep sequencer for the two-core SNN: Wishbone register window, per-core start/done
// handshake, global tick, timestep counter and completion/timeout interrupts.
module snn_tick_scheduler #(
  parameter logic [31:0] BASE_ADR = 32'h3000_0000,
  parameter int          TMO_W    = 16
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic [1:0]  core_en_o,
  output logic [1:0]  core_start_o,
  input  logic [1:0]  core_done_i,
  output logic        tick_o,
  output logic        busy_o,
  output logic        irq_o
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ISSUE = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_TICK  = 3'd3;
  localparam logic [2:0] ST_PAUSE = 3'd4;

  logic [2:0]       state_reg, state_next;
  logic             step_reg, free_reg, irq_en_reg;
  logic [1:0]       core_mask_reg;
  logic             done_reg, tmo_reg;
  logic [1:0]       done_latch_reg, done_latch_next;
  logic [15:0]      num_ticks_reg;
  logic [15:0]      tick_count_reg, tick_count_next;
  logic [1:0]       load_sel_reg;
  logic [TMO_W-1:0] timeout_reg;
  logic [TMO_W-1:0] tmo_cnt_reg, tmo_cnt_next;
  logic             set_done, set_tmo;

  // Bus decode; a new request is only accepted when no ack is outstanding.
  logic        wb_hit, wb_req, wb_wr;
  logic [5:0]  word;
  logic        wr_ctrl, wr_status, wr_nt, wr_ls, wr_to;
  assign wb_hit    = (wbs_adr_i[31:8] == BASE_ADR[31:8]);
  assign wb_req    = wbs_cyc_i & wbs_stb_i & wb_hit & ~wbs_ack_o;
  assign wb_wr     = wb_req & wbs_we_i;
  assign word      = wbs_adr_i[7:2];
  assign wr_ctrl   = wb_wr && (word == 6'h00);
  assign wr_status = wb_wr && (word == 6'h01);
  assign wr_nt     = wb_wr && (word == 6'h02);
  assign wr_ls     = wb_wr && (word == 6'h04);
  assign wr_to     = wb_wr && (word == 6'h05);

  logic unused_bits;
  assign unused_bits = ^{wbs_adr_i[1:0], wbs_dat_i};

  // Byte-lane merged write values, one bit at a time so any field width works.
  logic [15:0]      nt_new;
  logic [TMO_W-1:0] to_new;
  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_nt_lane
      assign nt_new[gi] = wbs_sel_i[gi/8] ? wbs_dat_i[gi] : num_ticks_reg[gi];
    end
    for (gi = 0; gi < TMO_W; gi++) begin : g_to_lane
      assign to_new[gi] = wbs_sel_i[gi/8] ? wbs_dat_i[gi] : timeout_reg[gi];
    end
  endgenerate

  logic       lane0_ctrl, lane0_status;
  logic       start_p, abort_p, clr_done, clr_tmo;
  logic       free_eff;
  logic [1:0] mask_eff;
  assign lane0_ctrl   = wr_ctrl & wbs_sel_i[0];
  assign lane0_status = wr_status & wbs_sel_i[0];
  assign start_p      = lane0_ctrl & wbs_dat_i[0];
  assign abort_p      = lane0_ctrl & wbs_dat_i[6];
  assign clr_done     = lane0_status & wbs_dat_i[3];
  assign clr_tmo      = lane0_status & wbs_dat_i[4];
  // A START written together with a new mask/FREE must see the new values.
  assign free_eff     = lane0_ctrl ? wbs_dat_i[2]   : free_reg;
  assign mask_eff     = lane0_ctrl ? wbs_dat_i[4:3] : core_mask_reg;

  logic [1:0] masked_done;
  logic [1:0] done_seen;
  assign masked_done = core_done_i & core_mask_reg;
  assign done_seen   = done_latch_reg | masked_done;

  always_comb begin
    state_next      = state_reg;
    done_latch_next = done_latch_reg;
    tick_count_next = tick_count_reg;
    tmo_cnt_next    = tmo_cnt_reg;
    set_done        = 1'b0;
    set_tmo         = 1'b0;
    if (abort_p) begin
      state_next = ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start_p) begin
            if ((mask_eff != 2'b00) && ((num_ticks_reg != 16'd0) || free_eff)) begin
              state_next      = ST_ISSUE;
              tick_count_next = 16'd0;
              done_latch_next = 2'b00;
            end else begin
              set_done = 1'b1;
            end
          end
        end
        ST_ISSUE: begin
          done_latch_next = 2'b00;
          tmo_cnt_next    = timeout_reg;
          state_next      = ST_WAIT;
        end
        ST_WAIT: begin
          done_latch_next = done_seen;
          if (done_seen == core_mask_reg) begin
            state_next = ST_TICK;
          end else if (timeout_reg != '0) begin
            if (tmo_cnt_reg <= TMO_W'(1)) begin
              tmo_cnt_next = '0;
              set_tmo      = 1'b1;
              state_next   = ST_IDLE;
            end else begin
              tmo_cnt_next = tmo_cnt_reg - TMO_W'(1);
            end
          end
        end
        ST_TICK: begin
          tick_count_next = tick_count_reg + 16'd1;
          if ((tick_count_next == num_ticks_reg) && !free_reg) begin
            state_next = ST_IDLE;
            set_done   = 1'b1;
          end else if (step_reg) begin
            state_next = ST_PAUSE;
          end else begin
            state_next = ST_ISSUE;
          end
        end
        ST_PAUSE: begin
          if (start_p) state_next = ST_ISSUE;
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  logic [31:0] rd_data;
  always_comb begin
    rd_data = 32'h0;
    case (word)
      6'h00: rd_data = {26'd0, irq_en_reg, core_mask_reg, free_reg, step_reg, 1'b0};
      6'h01: rd_data = {25'd0, done_latch_reg, tmo_reg, done_reg, state_reg};
      6'h02: rd_data = {16'd0, num_ticks_reg};
      6'h03: rd_data = {16'd0, tick_count_reg};
      6'h04: rd_data = {30'd0, load_sel_reg};
      6'h05: rd_data[TMO_W-1:0] = timeout_reg;
      default: rd_data = 32'h0;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wbs_ack_o      <= 1'b0;
      wbs_dat_o      <= 32'h0;
      state_reg      <= ST_IDLE;
      step_reg       <= 1'b0;
      free_reg       <= 1'b0;
      irq_en_reg     <= 1'b0;
      core_mask_reg  <= 2'b00;
      done_reg       <= 1'b0;
      tmo_reg        <= 1'b0;
      done_latch_reg <= 2'b00;
      num_ticks_reg  <= 16'd0;
      tick_count_reg <= 16'd0;
      load_sel_reg   <= 2'b00;
      timeout_reg    <= '0;
      tmo_cnt_reg    <= '0;
    end else begin
      wbs_ack_o      <= wb_req;
      wbs_dat_o      <= (wb_req && !wbs_we_i) ? rd_data : 32'h0;
      state_reg      <= state_next;
      done_latch_reg <= done_latch_next;
      tick_count_reg <= tick_count_next;
      tmo_cnt_reg    <= tmo_cnt_next;
      if (lane0_ctrl) begin
        step_reg      <= wbs_dat_i[1];
        free_reg      <= wbs_dat_i[2];
        core_mask_reg <= wbs_dat_i[4:3];
        irq_en_reg    <= wbs_dat_i[5];
      end
      if (wr_nt) num_ticks_reg <= nt_new;
      if (wr_ls && wbs_sel_i[0]) load_sel_reg <= wbs_dat_i[1:0];
      if (wr_to) timeout_reg <= to_new;
      // Set beats a simultaneous W1C.
      if (set_done)      done_reg <= 1'b1;
      else if (clr_done) done_reg <= 1'b0;
      if (set_tmo)       tmo_reg <= 1'b1;
      else if (clr_tmo)  tmo_reg <= 1'b0;
    end
  end

  logic [1:0] load_sel_pri;
  assign load_sel_pri = (load_sel_reg == 2'b11) ? 2'b01 : load_sel_reg;
  assign core_en_o    = ((state_reg == ST_IDLE) || (state_reg == ST_PAUSE)) ? load_sel_pri : 2'b00;
  assign core_start_o = (state_reg == ST_ISSUE) ? core_mask_reg : 2'b00;
  assign tick_o       = (state_reg == ST_TICK);
  assign busy_o       = (state_reg != ST_IDLE);
  assign irq_o        = irq_en_reg & (done_reg | tmo_reg);

endmodule
